// File: rtl/tetris_input_ctrl.sv
// Player-input conditioner: hysteretic joystick FSM with delayed auto-repeat,
// synchronised/debounced pushbuttons with press pulses, and an all-held game reset.
module tetris_input_ctrl #(
    parameter int ADC_W      = 12,
    parameter int LEFT_TH    = 1550,
    parameter int RIGHT_TH   = 1750,
    parameter int HYST       = 50,
    parameter int N_BTN      = 2,
    parameter int DEB_CYCLES = 500000,
    parameter int DAS_DELAY  = 8000000,
    parameter int DAS_RATE   = 2500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_value,
    input  logic             adc_valid,
    input  logic [N_BTN-1:0] btn_n,
    output logic             move_left,
    output logic             move_right,
    output logic [1:0]       dir_state,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             game_reset_n,
    output logic             led_red,
    output logic             led_green
);

    localparam int DAS_MAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
    localparam int DAS_CW  = $clog2(DAS_MAX + 1);
    localparam int DEB_CW  = $clog2(DEB_CYCLES + 1);

    localparam logic [ADC_W-1:0] LEFT_ENTER  = ADC_W'(LEFT_TH);
    localparam logic [ADC_W-1:0] RIGHT_ENTER = ADC_W'(RIGHT_TH);
    localparam logic [ADC_W-1:0] LEFT_REL    = ADC_W'(LEFT_TH + HYST);
    localparam logic [ADC_W-1:0] RIGHT_REL   = ADC_W'(RIGHT_TH - HYST);

    localparam logic [DAS_CW-1:0] DAS_FIRST_LAST = DAS_CW'(DAS_DELAY - 1);
    localparam logic [DAS_CW-1:0] DAS_RATE_LAST  = DAS_CW'(DAS_RATE - 1);
    localparam logic [DAS_CW-1:0] DAS_SAT        = DAS_CW'(DAS_MAX);
    localparam logic [DEB_CW-1:0] DEB_LAST       = DEB_CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        CENTER = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10
    } dir_t;

    dir_t              state_q, state_d;
    logic [DAS_CW-1:0] das_cnt_q, das_cnt_d;
    logic              das_rep_q, das_rep_d;
    logic              move_left_q, move_left_d;
    logic              move_right_q, move_right_d;

    logic [N_BTN-1:0]  sync1_q, sync1_d;
    logic [N_BTN-1:0]  sync2_q, sync2_d;
    logic [N_BTN-1:0]  btn_level_q, btn_level_d;
    logic [N_BTN-1:0]  btn_press_q, btn_press_d;
    logic [DEB_CW-1:0] deb_cnt_q [N_BTN];
    logic [DEB_CW-1:0] deb_cnt_d [N_BTN];

    function automatic logic [DAS_CW-1:0] das_sat_inc(input logic [DAS_CW-1:0] cnt);
        return (cnt == DAS_SAT) ? cnt : cnt + DAS_CW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        if (adc_valid) begin
            case (state_q)
                CENTER: begin
                    if (adc_value > RIGHT_ENTER)     state_d = RIGHT;
                    else if (adc_value < LEFT_ENTER) state_d = LEFT;
                end
                // A hard reversal outranks the release back to centre.
                RIGHT: begin
                    if (adc_value < LEFT_ENTER)      state_d = LEFT;
                    else if (adc_value <= RIGHT_REL) state_d = CENTER;
                end
                LEFT: begin
                    if (adc_value > RIGHT_ENTER)     state_d = RIGHT;
                    else if (adc_value >= LEFT_REL)  state_d = CENTER;
                end
                default: state_d = CENTER;
            endcase
        end

        das_cnt_d    = das_cnt_q;
        das_rep_d    = das_rep_q;
        move_left_d  = 1'b0;
        move_right_d = 1'b0;
        if (state_d != state_q) begin
            das_cnt_d    = '0;
            das_rep_d    = 1'b0;
            move_left_d  = (state_d == LEFT);
            move_right_d = (state_d == RIGHT);
        end else if (state_q != CENTER) begin
            // das_rep_q selects the shorter spacing once the first repeat has fired.
            if (das_cnt_q == (das_rep_q ? DAS_RATE_LAST : DAS_FIRST_LAST)) begin
                das_cnt_d    = '0;
                das_rep_d    = 1'b1;
                move_left_d  = (state_q == LEFT);
                move_right_d = (state_q == RIGHT);
            end else begin
                das_cnt_d = das_sat_inc(das_cnt_q);
            end
        end
    end

    always_comb begin
        sync1_d     = ~btn_n;
        sync2_d     = sync1_q;
        btn_level_d = btn_level_q;
        btn_press_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != btn_level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    btn_level_d[i] = ~btn_level_q[i];
                    btn_press_d[i] = ~btn_level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= CENTER;
            das_cnt_q    <= '0;
            das_rep_q    <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            btn_level_q  <= '0;
            btn_press_q  <= '0;
            for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            das_cnt_q    <= das_cnt_d;
            das_rep_q    <= das_rep_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            btn_level_q  <= btn_level_d;
            btn_press_q  <= btn_press_d;
            for (int i = 0; i < N_BTN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign move_left    = move_left_q;
    assign move_right   = move_right_q;
    assign dir_state    = state_q;
    assign btn_level    = btn_level_q;
    assign btn_press    = btn_press_q;
    assign game_reset_n = ~(&btn_level_q);
    assign led_red      = (state_q == RIGHT);
    assign led_green    = (state_q == LEFT);

endmodule
